mul_seq_ctrl: RTL and testbench

- Controller FSM for the repeated-addition multiplier datapath (P = A × B).
- Drives the load and decrement strobes of the B down-counter register, plus the A and P registers' controls.
- Observes the datapath's B-equals-zero status and exposes a start/done handshake to the host.
- This is the initiating end of the load/decrement control interface the datapath registers consume.

---
 rtl/mul_seq_ctrl.sv | 98 +++++++++
 tb/tb_mul_seq_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// Controller for the repeated-addition multiplier: sequences A/B/P register
// strobes, counts accumulate passes and flags runaway iteration as an error.
module mul_seq_ctrl #(
   parameter int CW       = 8,
   parameter int MAX_ITER = 200
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic          eqz,
   output logic          lda,
   output logic          ldb,
   output logic          clrp,
   output logic          ldp,
   output logic          decb,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [CW-1:0] iter_cnt
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LDA  = 3'd1,
      S_LDB  = 3'd2,
      S_TEST = 3'd3,
      S_ACC  = 3'd4,
      S_FIN  = 3'd5,
      S_ERR  = 3'd6
   } state_t;

   state_t state, state_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = S_IDLE;
      lda     = 1'b0;
      ldb     = 1'b0;
      clrp    = 1'b0;
      ldp     = 1'b0;
      decb    = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state)
         S_IDLE: state_n = start ? S_LDA : S_IDLE;
         S_LDA: begin
            lda     = 1'b1;
            busy    = 1'b1;
            state_n = S_LDB;
         end
         S_LDB: begin
            ldb     = 1'b1;
            clrp    = 1'b1;
            busy    = 1'b1;
            state_n = S_TEST;
         end
         S_TEST: begin
            busy = 1'b1;
            if (eqz)                            state_n = S_FIN;
            else if (iter_cnt == CW'(MAX_ITER)) state_n = S_ERR;
            else                                state_n = S_ACC;
         end
         S_ACC: begin
            ldp     = 1'b1;
            decb    = 1'b1;
            busy    = 1'b1;
            state_n = S_TEST;
         end
         S_FIN, S_ERR: begin
            done    = 1'b1;
            busy    = 1'b1;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
      // abort overrides every transition, including a start in IDLE
      if (abort) state_n = S_IDLE;
   end

   // err is raised on entry to ERR so it coincides with the done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iter_cnt <= '0;
         err      <= 1'b0;
      end else begin
         if (state == S_LDB)      iter_cnt <= '0;
         else if (state == S_ACC) iter_cnt <= iter_cnt + CW'(1);
         if (state_n == S_ERR)                         err <= 1'b1;
         else if (state == S_IDLE && state_n == S_LDA) err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl with a small B-register model feeding eqz.
module tb_mul_seq_ctrl;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n, start, abort, eqz;
   logic          lda, ldb, clrp, ldp, decb, busy, done, err;
   logic [CW-1:0] iter_cnt;

   int checks = 0;
   int fails  = 0;

   // {lda,ldb,clrp,ldp,decb,busy,done}
   localparam logic [6:0] O_IDLE = 7'b0000000;
   localparam logic [6:0] O_LDA  = 7'b1000010;
   localparam logic [6:0] O_LDB  = 7'b0110010;
   localparam logic [6:0] O_TEST = 7'b0000010;
   localparam logic [6:0] O_ACC  = 7'b0001110;
   localparam logic [6:0] O_FIN  = 7'b0000011;

   logic [6:0] outs;
   assign outs = {lda, ldb, clrp, ldp, decb, busy, done};

   mul_seq_ctrl #(.CW(CW), .MAX_ITER(5)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .eqz(eqz),
      .lda(lda), .ldb(ldb), .clrp(clrp), .ldp(ldp), .decb(decb),
      .busy(busy), .done(done), .err(err), .iter_cnt(iter_cnt)
   );

   always #5 clk = ~clk;

   // datapath stand-in: B register loaded on ldb, decremented on decb
   logic [7:0] b_val = 8'd0;
   logic [7:0] b_reg;
   logic       nz_force = 1'b0;
   int         pcnt = 0;
   int         dcnt = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)    b_reg <= 8'd0;
      else if (ldb)  b_reg <= b_val;
      else if (decb) b_reg <= b_reg - 8'd1;
   end
   assign eqz = nz_force ? 1'b0 : (b_reg == 8'd0);

   always @(posedge clk) begin
      if (ldp)  pcnt <= pcnt + 1;
      if (done) dcnt <= dcnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) chk("ldb_decb_excl", {31'd0, ldb & decb}, 32'd0);

   // expected outputs c cycles after the edge that accepted start, B=n
   function automatic logic [6:0] sched(input int n, input int c);
      if (c == 1)                      return O_LDA;
      if (c == 2)                      return O_LDB;
      if (c >= 3 && c < 2*n + 4)       return (c % 2 == 1) ? O_TEST : O_ACC;
      if (c == 2*n + 4)                return O_FIN;
      return O_IDLE;
   endfunction

   task automatic kick(input bit hold);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   int p0, d0;

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_outs", {25'd0, outs}, {25'd0, O_IDLE});
      chk("rst_iter", {24'd0, iter_cnt}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      // B=3: ACC at 4,6,8, done at 10
      b_val = 8'd3; p0 = pcnt; d0 = dcnt;
      kick(1'b0);
      for (int c = 1; c <= 11; c++) begin
         if (c > 1) step();
         chk($sformatf("b3_c%0d", c), {25'd0, outs}, {25'd0, sched(3, c)});
         if (c == 10) begin
            chk("b3_iter", {24'd0, iter_cnt}, 32'd3);
            chk("b3_err", {31'd0, err}, 32'd0);
         end
      end
      chk("b3_ldp_cnt", pcnt - p0, 32'd3);
      chk("b3_done_cnt", dcnt - d0, 32'd1);

      // B=0: done at 4, no accumulate
      b_val = 8'd0; p0 = pcnt;
      kick(1'b0);
      for (int c = 1; c <= 5; c++) begin
         if (c > 1) step();
         chk($sformatf("b0_c%0d", c), {25'd0, outs}, {25'd0, sched(0, c)});
      end
      chk("b0_ldp_cnt", pcnt - p0, 32'd0);
      chk("b0_iter", {24'd0, iter_cnt}, 32'd0);

      // eqz stuck low: five ACCs then ERR with done+err at 14
      b_val = 8'd9; nz_force = 1'b1; p0 = pcnt;
      kick(1'b0);
      for (int c = 1; c <= 15; c++) begin
         if (c > 1) step();
         chk($sformatf("err_c%0d", c), {25'd0, outs},
             {25'd0, (c <= 13) ? sched(5, c) : ((c == 14) ? O_FIN : O_IDLE)});
         if (c == 14) begin
            chk("err_flag", {31'd0, err}, 32'd1);
            chk("err_iter", {24'd0, iter_cnt}, 32'd5);
         end
      end
      chk("err_sticky", {31'd0, err}, 32'd1);
      chk("err_ldp_cnt", pcnt - p0, 32'd5);
      nz_force = 1'b0; b_val = 8'd1;
      kick(1'b0);
      chk("err_clr_lda", {31'd0, err}, 32'd0);
      chk("err_clr_outs", {25'd0, outs}, {25'd0, O_LDA});
      for (int c = 2; c <= 7; c++) begin
         step();
         chk($sformatf("b1_c%0d", c), {25'd0, outs}, {25'd0, sched(1, c)});
      end

      // B=4 with start pulsed during ACC: ignored, single done at 12
      b_val = 8'd4; d0 = dcnt;
      kick(1'b0);
      for (int c = 1; c <= 14; c++) begin
         if (c > 1) step();
         chk($sformatf("b4_c%0d", c), {25'd0, outs}, {25'd0, sched(4, c)});
         if (c == 6) start = 1'b1;
         if (c == 7) start = 1'b0;
      end
      chk("b4_done_cnt", dcnt - d0, 32'd1);

      // start held through FIN: IDLE at 7, second LDA at 8
      b_val = 8'd1;
      kick(1'b1);
      for (int c = 1; c <= 14; c++) begin
         if (c > 1) step();
         chk($sformatf("hold_c%0d", c), {25'd0, outs},
             {25'd0, (c <= 7) ? sched(1, c) : sched(1, c - 7)});
         if (c == 8) start = 1'b0;
      end

      // B=5, abort sampled at end of third ACC (cycle 8)
      b_val = 8'd5; d0 = dcnt;
      kick(1'b0);
      for (int c = 1; c <= 8; c++) begin
         if (c > 1) step();
         chk($sformatf("ab_c%0d", c), {25'd0, outs}, {25'd0, sched(5, c)});
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("ab_outs", {25'd0, outs}, {25'd0, O_IDLE});
      chk("ab_iter", {24'd0, iter_cnt}, 32'd3);
      step();
      chk("ab_idle", {25'd0, outs}, {25'd0, O_IDLE});
      chk("ab_no_done", dcnt - d0, 32'd0);

      // async reset in the second TEST of a B=2 run
      b_val = 8'd2;
      kick(1'b0);
      for (int c = 1; c <= 5; c++) begin
         if (c > 1) step();
         chk($sformatf("rm_c%0d", c), {25'd0, outs}, {25'd0, sched(2, c)});
      end
      chk("rm_iter_pre", {24'd0, iter_cnt}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rm_outs", {25'd0, outs}, {25'd0, O_IDLE});
      chk("rm_iter", {24'd0, iter_cnt}, 32'd0);
      chk("rm_err", {31'd0, err}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      kick(1'b0);
      for (int c = 1; c <= 9; c++) begin
         if (c > 1) step();
         chk($sformatf("post_c%0d", c), {25'd0, outs}, {25'd0, sched(2, c)});
         if (c == 8) chk("post_iter", {24'd0, iter_cnt}, 32'd2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
